// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - RV32M iterative multiply/divide sequencer (optional MULDIV_FAST_MUL_EN single-cycle multiply)
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [2:0]         f3;
    logic               neg;
    logic [WIDTH-1:0]   mcand;
    // Multiply: {high, low} product, low half starts as the multiplier.
    // Divide: high half is the partial remainder, low half the dividend/quotient.
    logic [2*WIDTH-1:0] prod;

    logic               sa_in, sb_in, neg_in;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               div_zero, div_ovf;
    logic [WIDTH-1:0]   special_res;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_diff;
    logic [WIDTH:0]     div_shift;
    logic [2*WIDTH-1:0] prod_nx;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   final_res;

    // Operand sign handling and special-divide detection, evaluated on the request.
    always_comb begin
        sa_in  = op_a[WIDTH-1] & (funct3 == 3'b001 || funct3 == 3'b010 ||
                                  funct3 == 3'b100 || funct3 == 3'b110);
        sb_in  = op_b[WIDTH-1] & (funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b110);
        // Remainder follows the dividend; everything else negates when signs differ.
        neg_in = (funct3 == 3'b110) ? sa_in : (sa_in ^ sb_in);
        mag_a  = sa_in ? (~op_a + 1'b1) : op_a;
        mag_b  = sb_in ? (~op_b + 1'b1) : op_b;
        div_zero = funct3[2] && (op_b == '0);
        div_ovf  = (funct3 == 3'b100 || funct3 == 3'b110) &&
                   (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
        if (funct3[1])
            special_res = div_zero ? op_a : '0;
        else
            special_res = div_zero ? '1 : {1'b1, {(WIDTH-1){1'b0}}};
    end

    // One shift-add or restoring-divide step, plus sign correction of the step's outcome.
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, mcand};
        if (!f3[2])
            prod_nx = {mul_sum, prod[WIDTH-1:1]};
        else if (!div_diff[WIDTH+1])
            prod_nx = {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
        else
            prod_nx = {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
        prod_signed = neg ? (~prod_nx + 1'b1) : prod_nx;
        case (f3)
            3'b000:         final_res = prod_signed[WIDTH-1:0];
            3'b001, 3'b010,
            3'b011:         final_res = prod_signed[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: final_res = neg ? (~prod_nx[WIDTH-1:0] + 1'b1) : prod_nx[WIDTH-1:0];
            default:        final_res = neg ? (~prod_nx[2*WIDTH-1:WIDTH] + 1'b1)
                                            : prod_nx[2*WIDTH-1:WIDTH];
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [WIDTH:0]     fast_a, fast_b;
    logic signed [2*WIDTH+1:0] fast_p;
    logic [WIDTH-1:0]          fast_res;

    // Single-cycle multiply on sign-extended (WIDTH+1)-bit operands.
    always_comb begin
        fast_a   = {(op_a[WIDTH-1] & (funct3 == 3'b001 || funct3 == 3'b010)), op_a};
        fast_b   = {(op_b[WIDTH-1] & (funct3 == 3'b001)), op_b};
        fast_p   = fast_a * fast_b;
        fast_res = (funct3 == 3'b000) ? fast_p[WIDTH-1:0] : fast_p[2*WIDTH-1:WIDTH];
    end
`endif

    // Sequencer FSM with registered done/result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            f3     <= '0;
            neg    <= 1'b0;
            mcand  <= '0;
            prod   <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        f3    <= funct3;
                        neg   <= neg_in;
                        count <= '0;
                        if (div_zero || div_ovf) begin
                            result <= special_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!funct3[2]) begin
                            result <= fast_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
`endif
                        else begin
                            mcand <= mag_b;
                            prod  <= {{WIDTH{1'b0}}, mag_a};
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        prod  <= prod_nx;
                        count <= count + 1'b1;
                        if (count == CNT_W'(WIDTH-1)) begin
                            result <= final_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign stall = rst_n & (((state == IDLE) & start & ~flush) | (state == CALC));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
    localparam int MUL_STALLS = 0;
`else
    localparam int MUL_LAT = 33;
    localparam int MUL_STALLS = 32;
`endif

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op in the current IDLE cycle, optionally keep start high with junk
    // operands while busy, then check latency, stall count, result and the done pulse width.
    task automatic run_op(input string tag, input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int exp_stalls, input bit hold_start);
        int lat;
        int stalls;
        @(negedge clk);
        funct3 = fn; op_a = a; op_b = b; start = 1'b1;
        #1;
        check({tag, "_stall_c0"}, {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        if (hold_start) begin
            funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
        end else begin
            start = 1'b0;
        end
        lat = 1;
        stalls = 0;
        while (!done && lat < 100) begin
            if (stall) stalls++;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_stalls"}, stalls, exp_stalls);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mul_6x7",   3'b000, 32'd6,          32'd7,          32'd42,         MUL_LAT, MUL_STALLS, 0);
        run_op("mulhu",     3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  MUL_LAT, MUL_STALLS, 0);
        run_op("mulh",      3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  MUL_LAT, MUL_STALLS, 0);
        run_op("mulhsu",    3'b010, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  MUL_LAT, MUL_STALLS, 0);
        run_op("div_m7_2",  3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, 32, 0);
        run_op("rem_m7_2",  3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, 32, 0);
        run_op("divu_100_7",3'b101, 32'd100,        32'd7,          32'd14,         33, 32, 0);
        run_op("remu_100_7",3'b111, 32'd100,        32'd7,          32'd2,          33, 32, 0);
        run_op("divu_5_0",  3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1, 0, 0);
        run_op("rem_5_0",   3'b110, 32'd5,          32'd0,          32'd5,          1, 0, 0);
        run_op("div_ovf",   3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1, 0, 0);

        // Flush a DIV at cycle 10: no done, result keeps the previous value.
        @(negedge clk);
        funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            check("flush_nodone", {31'b0, done}, 32'd0);
        end
        check("flush_busy_c10", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle", {31'b0, busy}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        check("flush_result", result, 32'h8000_0000);
        run_op("div_after_flush", 3'b100, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, 33, 32, 0);

        // start held high with different operands while busy must be ignored.
        run_op("mul_hold_start", 3'b000, 32'd3, 32'd5, 32'd15, MUL_LAT, MUL_STALLS, 1);

        // Back-to-back: DIVU then MUL, each issued in the IDLE cycle after the previous DONE.
        run_op("b2b_divu", 3'b101, 32'd1000, 32'd10,  32'd100,    33, 32, 0);
        run_op("b2b_mul",  3'b000, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, MUL_LAT, MUL_STALLS, 0);

        // Asynchronous reset in the middle of an iterative divide.
        @(negedge clk);
        funct3 = 3'b101; op_a = 32'd77; op_b = 32'd5; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("midrst_busy_before", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_stall", {31'b0, stall}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after_rst_remu", 3'b111, 32'd77, 32'd5, 32'd2, 33, 32, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
